// File: rtl/conv_frame_writer_pkg.sv
// Shared definitions for the convolution output frame writer: FSM states,
// BRAM performance mode and the address-width helper.
package conv_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  localparam string RAM_PERFORMANCE = "LOW_LATENCY";

  // Bits needed to hold the value 'depth'.
  function automatic int clogb2(input int depth);
    int d;
    int n;
    d = depth;
    n = 0;
    while (d > 0) begin
      n = n + 1;
      d = d >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/xilinx_single_port_ram_no_change.sv
// Single-port block RAM, no-change write mode (read data holds during writes).
// LOW_LATENCY gives a 1-cycle read; HIGH_PERFORMANCE adds an output register.
module xilinx_single_port_ram_no_change #(
  parameter int    RAM_WIDTH       = 8,
  parameter int    RAM_DEPTH       = 1024,
  parameter int    ADDR_W          = 10,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                 clka,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [RAM_WIDTH-1:0] dina,
  input  logic                 wea,
  input  logic                 ena,
  input  logic                 rsta,
  input  logic                 regcea,
  output logic [RAM_WIDTH-1:0] douta
);

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] r_ram_data;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) r_mem[addra] <= dina;
      else     r_ram_data   <= r_mem[addra];
    end
  end

  generate
    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low_latency
      logic w_unused_ctl;
      assign w_unused_ctl = &{1'b0, rsta, regcea};
      assign douta = r_ram_data;
    end else begin : g_high_performance
      logic [RAM_WIDTH-1:0] r_douta;
      always_ff @(posedge clka) begin
        if (rsta)        r_douta <= '0;
        else if (regcea) r_douta <= r_ram_data;
      end
      assign douta = r_douta;
    end
  endgenerate

endmodule

// File: rtl/conv_frame_writer.sv
// Collects column-major convolver results into a row-major BRAM frame, then streams it out.
// CONV_WRITER_SAT_EN: saturate shifted results to pixel range instead of truncating.
//
// state   | meaning
// COLLECT | accepting convolver results, writing them to BRAM
// FETCH   | BRAM address set to rd_addr (waits out a pending final write)
// CAPTURE | BRAM read data latched into o_data, o_valid raised
// HOLD    | o_data held until downstream takes it
module conv_frame_writer
  import conv_frame_writer_pkg::*;
#(
  parameter int RAM_WIDTH    = 8,
  parameter int RAM_DEPTH    = 2**16,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int KERNEL_WIDTH = 3,
  parameter int CONV_WIDTH   = 20,
  parameter int SHIFT        = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_valid,
  input  logic signed [CONV_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [RAM_WIDTH-1:0]         o_data,
  input  logic                         i_ready,
  output logic                         o_frame_done
);

  localparam int OUT_W  = IMAGE_WIDTH - KERNEL_WIDTH + 1;
  localparam int OUT_H  = IMAGE_HEIGHT - KERNEL_WIDTH + 1;
  localparam int NPIX   = OUT_W * OUT_H;
  localparam int ADDR_W = clogb2(RAM_DEPTH - 1);

  localparam logic [ADDR_W-1:0] A_ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OUT_W    = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] A_LAST_ROW = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] A_LAST_COL = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] A_LAST_PIX = ADDR_W'(NPIX - 1);

  generate
    if (NPIX > RAM_DEPTH) begin : g_size_check
      $error("conv_frame_writer: output frame does not fit in RAM_DEPTH");
    end
  endgenerate

`ifdef CONV_WRITER_SAT_EN
  localparam logic signed [CONV_WIDTH-1:0] PIX_MAX = CONV_WIDTH'((1 << RAM_WIDTH) - 1);
`endif

  function automatic logic [RAM_WIDTH-1:0] clip(input logic signed [CONV_WIDTH-1:0] d);
    logic signed [CONV_WIDTH-1:0] v;
    v = d >>> SHIFT;
`ifdef CONV_WRITER_SAT_EN
    if (v < 0)            clip = '0;
    else if (v > PIX_MAX) clip = '1;
    else                  clip = v[RAM_WIDTH-1:0];
`else
    clip = v[RAM_WIDTH-1:0];
`endif
  endfunction

  state_t               r_state;
  logic [ADDR_W-1:0]    r_col;
  logic [ADDR_W-1:0]    r_row;
  logic [ADDR_W-1:0]    r_row_base;
  logic [ADDR_W-1:0]    r_rd_addr;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [RAM_WIDTH-1:0] r_dina;
  logic                 r_wea;
  logic [ADDR_W-1:0]    w_addra;
  logic [RAM_WIDTH-1:0] w_douta;

  // A pending write owns the port; otherwise the read address is presented.
  assign w_addra = r_wea ? r_wr_addr : r_rd_addr;

  xilinx_single_port_ram_no_change #(
    .RAM_WIDTH       (RAM_WIDTH),
    .RAM_DEPTH       (RAM_DEPTH),
    .ADDR_W          (ADDR_W),
    .RAM_PERFORMANCE (RAM_PERFORMANCE)
  ) u_ram (
    .clka   (clk),
    .addra  (w_addra),
    .dina   (r_dina),
    .wea    (r_wea),
    .ena    (1'b1),
    .rsta   (reset),
    .regcea (1'b1),
    .douta  (w_douta)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_COLLECT;
      r_col        <= '0;
      r_row        <= '0;
      r_row_base   <= '0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_dina       <= '0;
      r_wea        <= 1'b0;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          r_wea   <= 1'b0;
          if (i_valid && o_ready) begin
            r_wea     <= 1'b1;
            r_wr_addr <= r_row_base + r_col;
            r_dina    <= clip(i_data);
            if (r_row == A_LAST_ROW) begin
              r_row      <= '0;
              r_row_base <= '0;
              if (r_col == A_LAST_COL) begin
                r_col        <= '0;
                r_rd_addr    <= '0;
                o_ready      <= 1'b0;
                o_frame_done <= 1'b1;
                r_state      <= ST_FETCH;
              end else begin
                r_col <= r_col + A_ONE;
              end
            end else begin
              r_row      <= r_row + A_ONE;
              r_row_base <= r_row_base + A_OUT_W;
            end
          end
        end
        ST_FETCH: begin
          // The frame's last write lands during the first FETCH cycle; read once it is done.
          r_wea   <= 1'b0;
          o_valid <= 1'b0;
          if (!r_wea) r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          o_data  <= w_douta;
          o_valid <= 1'b1;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (r_rd_addr == A_LAST_PIX) begin
              r_rd_addr <= '0;
              o_ready   <= 1'b1;
              r_state   <= ST_COLLECT;
            end else begin
              r_rd_addr <= r_rd_addr + A_ONE;
              r_state   <= ST_FETCH;
            end
          end
        end
        default: begin
          r_state    <= ST_COLLECT;
          r_col      <= '0;
          r_row      <= '0;
          r_row_base <= '0;
          r_rd_addr  <= '0;
          r_wea      <= 1'b0;
          o_ready    <= 1'b1;
          o_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Scoreboard bench for conv_frame_writer: a 5x5/SHIFT=2 instance for the small-frame
// directed cases and a 10x10 instance for the 64-pixel reorder case.
module tb_conv_frame_writer;

  localparam int CW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_a, a_i_valid, a_o_ready, a_o_valid, a_i_ready, a_done;
  logic signed [CW-1:0] a_i_data;
  logic [7:0]           a_o_data;
  logic                 reset_b, b_i_valid, b_o_ready, b_o_valid, b_i_ready, b_done;
  logic signed [CW-1:0] b_i_data;
  logic [7:0]           b_o_data;

  conv_frame_writer #(
    .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .KERNEL_WIDTH(3), .CONV_WIDTH(CW), .SHIFT(2)
  ) dut_a (
    .clk(clk), .reset(reset_a), .i_valid(a_i_valid), .i_data(a_i_data),
    .o_ready(a_o_ready), .o_valid(a_o_valid), .o_data(a_o_data),
    .i_ready(a_i_ready), .o_frame_done(a_done)
  );

  conv_frame_writer #(
    .IMAGE_WIDTH(10), .IMAGE_HEIGHT(10), .KERNEL_WIDTH(3), .CONV_WIDTH(CW), .SHIFT(0)
  ) dut_b (
    .clk(clk), .reset(reset_b), .i_valid(b_i_valid), .i_data(b_i_data),
    .o_ready(b_o_ready), .o_valid(b_o_valid), .o_data(b_o_data),
    .i_ready(b_i_ready), .o_frame_done(b_done)
  );

  int checks = 0;
  int failures = 0;
  int qa[$];
  int qb[$];
  int a_pops = 0, a_done_cnt = 0, b_done_cnt = 0;
  int ex_a[9];
  int ex_b[64];
  logic [7:0] a_held;
  bit a_holding = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor A: pops on every handshake, checks hold stability and o_ready during drain.
  always @(negedge clk) begin
    if (a_done === 1'b1) a_done_cnt++;
    if (a_o_valid === 1'b1) begin
      chk("a_ready_low_while_valid", int'(a_o_ready), 0);
      if (a_holding) chk("a_data_stable_held", int'(a_o_data), int'(a_held));
      if (a_i_ready) begin
        a_holding = 0;
        a_pops++;
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL a_extra_pixel actual=%0d expected=none", a_o_data);
        end else begin
          automatic int e = qa.pop_front();
          if (int'(a_o_data) !== e) begin
            failures++;
            $display("FAIL a_pixel actual=%0d expected=%0d", a_o_data, e);
          end
        end
      end else begin
        a_holding = 1;
        a_held = a_o_data;
      end
    end else begin
      a_holding = 0;
    end
  end

  always @(negedge clk) begin
    if (b_done === 1'b1) b_done_cnt++;
    if (b_o_valid === 1'b1 && b_i_ready) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_extra_pixel actual=%0d expected=none", b_o_data);
      end else begin
        automatic int e = qb.pop_front();
        if (int'(b_o_data) !== e) begin
          failures++;
          $display("FAIL b_pixel actual=%0d expected=%0d", b_o_data, e);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_a(input int v);
    int n;
    n = 0;
    a_i_valid = 1'b1;
    a_i_data  = CW'(v);
    while (!a_o_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("a_send_timeout", n, 0);
    @(negedge clk);
    a_i_valid = 1'b0;
  endtask

  task automatic send_b(input int v);
    int n;
    n = 0;
    b_i_valid = 1'b1;
    b_i_data  = CW'(v);
    while (!b_o_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("b_send_timeout", n, 0);
    @(negedge clk);
    b_i_valid = 1'b0;
  endtask

  // Expected read order is row-major over a column-major sent frame.
  task automatic push_a();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        qa.push_back(ex_a[c*3 + r]);
  endtask

  task automatic send_frame_a(input int base, input bit gaps);
    for (int k = 0; k < 9; k++) begin
      ex_a[k] = base + k;
      send_a((base + k) * 4);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    push_a();
  endtask

  task automatic drain_a(input string nm, input int done_before);
    int n;
    n = 0;
    while (qa.size() != 0 && n < 1000) begin
      @(negedge clk);
      #1;
      chk({nm, "_ready_low_drain"}, int'(a_o_ready), 0);
      n++;
    end
    a_i_valid = 1'b0;
    chk({nm, "_drain_left"}, qa.size(), 0);
    n = 0;
    while (!a_o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_back_to_collect"}, int'(a_o_ready), 1);
    chk({nm, "_frame_done_once"}, a_done_cnt - done_before, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    reset_a = 1; reset_b = 1;
    a_i_valid = 0; a_i_data = '0; a_i_ready = 1;
    b_i_valid = 0; b_i_data = '0; b_i_ready = 1;
    repeat (3) @(negedge clk);
    chk("a_rst_ready", int'(a_o_ready), 1);
    chk("a_rst_valid", int'(a_o_valid), 0);
    chk("a_rst_data", int'(a_o_data), 0);
    chk("a_rst_done", int'(a_done), 0);
    chk("b_rst_ready", int'(b_o_ready), 1);
    chk("b_rst_valid", int'(b_o_valid), 0);
    reset_a = 0; reset_b = 0;
    @(negedge clk);

    // Back-to-back frame 0..8
    d0 = a_done_cnt;
    send_frame_a(0, 0);
    drain_a("t1", d0);

    // Random gaps on input, i_ready low 5 cycles mid-drain
    d0 = a_done_cnt;
    send_frame_a(0, 1);
    n = 0;
    while (a_pops < 13 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t2_pops_before_stall", a_pops, 13);
    @(negedge clk);
    a_i_ready = 0;
    repeat (5) @(negedge clk);
    a_i_ready = 1;
    drain_a("t2", d0);

    // Clip behaviour with SHIFT=2
    d0 = a_done_cnt;
`ifdef CONV_WRITER_SAT_EN
    ex_a[0] = 0;
`else
    ex_a[0] = 246;
`endif
    ex_a[1] = 255;
    ex_a[2] = 100;
    send_a(-40);
    send_a(1023);
    send_a(400);
    for (int k = 3; k < 9; k++) begin
      ex_a[k] = k - 2;
      send_a((k - 2) * 4);
    end
    push_a();
    drain_a("t3", d0);

    // Reset after a partial frame
    for (int k = 1; k <= 4; k++) send_a(k * 4);
    reset_a = 1;
    @(negedge clk);
    chk("t4_rst_ready", int'(a_o_ready), 1);
    chk("t4_rst_valid", int'(a_o_valid), 0);
    @(negedge clk);
    reset_a = 0;
    @(negedge clk);
    d0 = a_done_cnt;
    send_frame_a(10, 0);
    drain_a("t4", d0);

    // i_valid held with 99 during drain must not leak into the next frame
    d0 = a_done_cnt;
    send_frame_a(30, 0);
    a_i_valid = 1'b1;
    a_i_data  = CW'(99 * 4);
    drain_a("t5", d0);
    d0 = a_done_cnt;
    send_frame_a(20, 1);
    drain_a("t5b", d0);

    // 10x10 image: 8x8 output frame
    d0 = b_done_cnt;
    for (int k = 0; k < 64; k++) begin
      ex_b[k] = (k * 3 + 1) % 256;
      send_b(ex_b[k]);
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        qb.push_back(ex_b[c*8 + r]);
    n = 0;
    while (qb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_drain_left", qb.size(), 0);
    repeat (3) @(negedge clk);
    chk("t6_back_to_collect", int'(b_o_ready), 1);
    chk("t6_frame_done_once", b_done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
